sqrt_iter_core: RTL and testbench
=================================

Name: sqrt_iter_core

Overview:
- Sequential integer square-root engine that sits directly downstream of the calculator's sqrt peripheral wrapper.
- The wrapper drives it with a start pulse and operand, and reads back root and status.
- Computes floor(sqrt(A)) and the remainder using a restoring digit-by-digit algorithm, one result bit per clock.
- Provides a done pulse plus sticky valid/exact flags for polling by the FemtoRV32 bus wrapper.

Parameters:
- IN_W, 16, operand width in bits; must be even and >= 4.
- OUT_W, IN_W/2, root width (localparam, not overridable).
- REM_W, IN_W/2+1, remainder width (localparam, not overridable).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled only in IDLE.
- A  input  IN_W  operand, captured on the edge that accepts start.
- X  output  OUT_W  root result, registered.
- R  output  REM_W  remainder A - X*X, registered.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when X/R update.
- valid  output  1  sticky: X/R hold a completed result.
- exact  output  1  sticky: last result had R == 0.

Behaviour:
- Reset (reset == 0, asynchronous): state=IDLE; X=0, R=0, busy=0, done=0, valid=0, exact=0; internal registers cleared.
- States:
  - IDLE: if start=1 at a rising edge, load a_sh=A, r_acc=0, q_acc=0, cnt=OUT_W-1; set busy=1; clear valid and exact; go to CALC. Otherwise hold all state.
  - CALC: one iteration per edge:
    - t = {r_acc, a_sh[IN_W-1:IN_W-2]} - {q_acc, 2'b01}, evaluated at REM_W+1 bits.
    - If t is non-negative: r_acc=t and q_acc={q_acc,1}. Else r_acc={r_acc,a_sh top two bits} and q_acc={q_acc,0}.
    - Then a_sh <<= 2 and cnt decrements.
  - Last iteration (cnt==0 edge): write X and R from the final iteration values; set done=1, valid=1, exact=(final R==0); clear busy; go to IDLE.
- Latency: the result appears exactly OUT_W rising edges after the edge that accepted start (8 for IN_W=16). done is high for the single cycle that follows.
- Cleared on the next edge: done.
- Held until next accepted start or reset: valid, exact, X, R.
- Ignored while busy: start is not queued. A changing during CALC has no effect.
- Back-to-back: start high during the done cycle is accepted, because state is IDLE then. X/R keep the old result until the new one is written; valid drops on acceptance.
- Reset mid-CALC: aborts immediately to reset values, with no done pulse.
- Arithmetic:
  - All unsigned.
  - R <= 2*X is always satisfied, so REM_W bits never overflow.
  - Compare uses the sign bit of the REM_W+1-bit difference.
- Boundaries:
  - A=0 gives X=0, R=0, exact=1.
  - A=2^IN_W-1 gives X=2^OUT_W-1, R=2^(OUT_W+1)-2.

Decomposition:
- Shared package sqrt_pkg:
  - state enum (IDLE, CALC);
  - width helper constants derived from IN_W.
- The wrapper imports the same package.
- No sub-module: the single iteration step is a combinational expression inside the core. A separate block is not justified.

Test Plan:
- Reset then A=144, start 1 cycle -> busy 8 cycles; done pulse with X=12, R=0, valid=1, exact=1.
- A=200 -> X=14, R=4, exact=0. A=0 -> X=0, R=0, exact=1. A=65535 -> X=255, R=510.
- Start A=100, then start A=9 while busy -> second start ignored; X=10; only one done pulse.
- Start A=50, then start A=81 held in the done cycle -> first done gives X=7, R=1. Second done follows 8 edges later with X=9, R=0; valid low in between.
- Reset driven 0 on the 4th CALC cycle -> all outputs 0 asynchronously, no done pulse; a subsequent start with A=25 gives X=5.
- Random sweep of 2000 operands versus reference model: X*X <= A < (X+1)^2, R == A-X*X, latency always 8.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative integer square-root engine and its bus wrapper.
// Holds the FSM state type and the width helpers derived from the operand width.
package sqrt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int unsigned SQRT_IN_W = 16;

    function automatic int unsigned root_w(input int unsigned in_w);
        return in_w / 2;
    endfunction

    function automatic int unsigned rem_w(input int unsigned in_w);
        return (in_w / 2) + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned in_w);
        return $clog2(in_w / 2);
    endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit integer square root: one root bit per clock.
// X/R/valid/exact are sticky until the next accepted start; done pulses for one cycle.
module sqrt_iter_core
    import sqrt_pkg::*;
#(
    parameter int IN_W = SQRT_IN_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_W-1:0]           A,
    output logic [root_w(IN_W)-1:0]   X,
    output logic [rem_w(IN_W)-1:0]    R,
    output logic                      busy,
    output logic                      done,
    output logic                      valid,
    output logic                      exact
);

    localparam int OUT_W = root_w(IN_W);
    localparam int REM_W = rem_w(IN_W);
    localparam int CNT_W = cnt_w(IN_W);

    state_t            state_r;
    logic [IN_W-1:0]   a_sh_r;
    logic [OUT_W-1:0]  r_acc_r;
    logic [OUT_W-1:0]  q_acc_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [REM_W:0]    trial_s;
    logic [REM_W:0]    sub_s;
    logic [REM_W:0]    diff_s;
    logic [REM_W-1:0]  r_next_s;
    logic [OUT_W-1:0]  q_next_s;

    // Single restoring step; the partial remainder never exceeds 2*q so REM_W+1 bits hold the trial.
    always_comb begin
        trial_s  = {r_acc_r, a_sh_r[IN_W-1:IN_W-2]};
        sub_s    = {q_acc_r, 2'b01};
        diff_s   = trial_s - sub_s;
        r_next_s = {REM_W{1'b0}};
        q_next_s = {OUT_W{1'b0}};
        if (diff_s[REM_W] == 1'b0) begin
            r_next_s = diff_s[REM_W-1:0];
            q_next_s = {q_acc_r[OUT_W-2:0], 1'b1};
        end else begin
            r_next_s = trial_s[REM_W-1:0];
            q_next_s = {q_acc_r[OUT_W-2:0], 1'b0};
        end
    end

    // Control FSM, datapath accumulators and registered result/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            a_sh_r  <= {IN_W{1'b0}};
            r_acc_r <= {OUT_W{1'b0}};
            q_acc_r <= {OUT_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            X       <= {OUT_W{1'b0}};
            R       <= {REM_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            exact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= A;
                        r_acc_r <= {OUT_W{1'b0}};
                        q_acc_r <= {OUT_W{1'b0}};
                        cnt_r   <= CNT_W'(OUT_W - 1);
                        busy    <= 1'b1;
                        valid   <= 1'b0;
                        exact   <= 1'b0;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    r_acc_r <= r_next_s[OUT_W-1:0];
                    q_acc_r <= q_next_s;
                    a_sh_r  <= {a_sh_r[IN_W-3:0], 2'b00};
                    cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        X       <= q_next_s;
                        R       <= r_next_s;
                        done    <= 1'b1;
                        valid   <= 1'b1;
                        exact   <= (r_next_s == {REM_W{1'b0}});
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= CALC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter_core.sv
// Self-checking bench for sqrt_iter_core: transaction-level reference model compared every cycle,
// plus directed operations with hand-computed roots and a random sweep.
module tb_sqrt_iter_core;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int REM_W = 9;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [IN_W-1:0]   A     = '0;
    logic [OUT_W-1:0]  X;
    logic [REM_W-1:0]  R;
    logic              busy, done, valid, exact;

    int checks = 0;
    int errors = 0;

    sqrt_iter_core #(.IN_W(IN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A),
        .X(X), .R(R), .busy(busy), .done(done), .valid(valid), .exact(exact)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int a);
        int x = 0;
        while ((x + 1) * (x + 1) <= a) x++;
        return x;
    endfunction

    // Reference model: remaining-edge counter and result computed by plain arithmetic.
    int m_rem   = 0;
    int m_op    = 0;
    int m_x     = 0;
    int m_r     = 0;
    bit m_busy  = 0;
    bit m_done  = 0;
    bit m_valid = 0;
    bit m_exact = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0; m_x = 0; m_r = 0;
            m_busy = 0; m_done = 0; m_valid = 0; m_exact = 0;
        end else begin
            m_done = 0;
            if (m_rem == 0) begin
                if (start) begin
                    m_op = int'(A); m_rem = OUT_W;
                    m_busy = 1; m_valid = 0; m_exact = 0;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_x = isqrt(m_op);
                    m_r = m_op - m_x * m_x;
                    m_done = 1; m_valid = 1; m_exact = (m_r == 0);
                    m_busy = 0;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        logic [OUT_W+REM_W+3:0] act, exp_v;
        act   = {X, R, busy, done, valid, exact};
        exp_v = {OUT_W'(m_x), REM_W'(m_r), m_busy, m_done, m_valid, m_exact};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual X=%0d R=%0d b=%b d=%b v=%b e=%b required X=%0d R=%0d b=%b d=%b v=%b e=%b",
                     $time, X, R, busy, done, valid, exact, m_x, m_r, m_busy, m_done, m_valid, m_exact);
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pulse start with operand a, wait for done, check latency and result.
    task automatic run_op(input int a, input int ex, input int er, input int ee);
        int cyc;
        start = 1'b1;
        A     = IN_W'(a);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("valid_drop_on_accept", int'(valid), 0);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
        check("latency", cyc, OUT_W);
        check("X", int'(X), ex);
        check("R", int'(R), er);
        check("exact", int'(exact), ee);
        check("valid", int'(valid), 1);
    endtask

    initial begin
        int a, x, r, pulses;

        // Pin the model with hand-computed roots.
        check("model_144", isqrt(144), 12);
        check("model_200", isqrt(200), 14);
        check("model_65535", isqrt(65535), 255);
        check("model_50", isqrt(50), 7);

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({X, R, busy, done, valid, exact}), 0);
        reset = 1'b1;
        @(negedge clk);

        run_op(144, 12, 0, 1);
        run_op(200, 14, 4, 0);
        run_op(0, 0, 0, 1);
        run_op(65535, 255, 510, 0);

        // Start while busy is ignored; only one done pulse follows.
        @(negedge clk);
        start = 1'b1; A = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; A = 16'd9;
        @(negedge clk);
        start = 1'b0; A = 16'd0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("busy_ignore_X", int'(X), 10);
            end
        end
        check("busy_ignore_pulses", pulses, 1);

        // Back-to-back: second start accepted in the done cycle.
        @(negedge clk);
        run_op(50, 7, 1, 0);
        run_op(81, 9, 0, 1);

        // Asynchronous reset on the 4th CALC cycle.
        @(negedge clk);
        start = 1'b1; A = 16'd144;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("async_reset_outputs", int'({X, R, busy, done, valid, exact}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(25, 5, 0, 1);

        // Random sweep against the arithmetic definition.
        for (int i = 0; i < 2000; i++) begin
            a = int'($urandom_range(0, 65535));
            x = isqrt(a);
            r = a - x * x;
            run_op(a, x, r, int'(r == 0));
            check("sweep_bound", int'(int'(X) * int'(X) <= a && a < (int'(X) + 1) * (int'(X) + 1)), 1);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
